// File: rtl/seq_alu_system_if.sv
// ---------------------------------------------------------------------------
// seq_alu_system_if
// Request/result bundle for the sequential ALU system.
//   start       request pulse, only looked at while the ALU is idle
//   op          opcode: 00 add, 01 sub, 10 and, 11 mul
//   inpA, inpB  operands, WIDTH bits
//   solution    last result (registered)
//   ovf         overflow/borrow flag of the last result (registered)
//   busy        high from an accepted request until the FSM is idle again
//   done        high while the FSM sits in DONE
//   prStateLed  present state code
//   nxStateLed  state code that the next tick edge will load
// Modports: master drives the request side, slave is the ALU itself.
// ---------------------------------------------------------------------------
interface seq_alu_system_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] inpA;
    logic [WIDTH-1:0] inpB;
    logic [WIDTH-1:0] solution;
    logic             ovf;
    logic             busy;
    logic             done;
    logic [2:0]       prStateLed;
    logic [2:0]       nxStateLed;

    modport master (
        output start, op, inpA, inpB,
        input  solution, ovf, busy, done, prStateLed, nxStateLed
    );

    modport slave (
        input  start, op, inpA, inpB,
        output solution, ovf, busy, done, prStateLed, nxStateLed
    );
endinterface

// File: rtl/seq_alu_system.sv
// ---------------------------------------------------------------------------
// seq_alu_system
// Multi-cycle ALU: controller FSM, operand/accumulator datapath and a tick
// divider in one block. The FSM only moves on tick edges; multiplication is
// done by repeated addition, one addition per tick.
// Parameters:
//   WIDTH     operand/result width (>= 2)
//   TICK_DIV  FSM advances once every TICK_DIV clocks (>= 1)
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    seq_alu_system_if slave modport (request, result, state LEDs)
// Build option:
//   SEQ_ALU_SAT_EN  when defined, add/mul overflow saturates to all-ones and
//                   a subtract borrow saturates to zero; ovf is still set.
//                   When undefined, results wrap modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module seq_alu_system #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 8
) (
    input logic             clk,
    input logic             reset,
    seq_alu_system_if.slave bus
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_MULT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    logic [CNT_W-1:0] tickCnt_q, tickCnt_d;
    logic [2:0]       state_q, state_d, stateNext;
    logic             pending_q, pending_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] regA_q, regA_d;
    logic [WIDTH-1:0] regB_q, regB_d;
    logic [1:0]       regOp_q, regOp_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] iter_q, iter_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] solution_q, solution_d;
    logic             ovf_q, ovf_d;

    logic             tick;
    logic [WIDTH:0]   addExt;
    logic [WIDTH:0]   accExt;

    assign tick   = (tickCnt_q == CNT_W'(TICK_DIV - 1));
    assign addExt = {1'b0, regA_q} + {1'b0, regB_q};
    assign accExt = {1'b0, acc_q} + {1'b0, regA_q};

    // Next-state decode, independent of tick so it can drive nxStateLed;
    // the state register only takes it on a tick edge.
    always_comb begin
        stateNext = S_IDLE;
        case (state_q)
            S_IDLE:  stateNext = (bus.start || pending_q) ? S_LOAD : S_IDLE;
            S_LOAD:  stateNext = (regOp_q == OP_MUL) ? S_MULT : S_EXEC;
            S_EXEC:  stateNext = S_DONE;
            S_MULT:  stateNext = (iter_q == '0) ? S_DONE : S_MULT;
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Datapath next values. Capture happens on any clock in IDLE, everything
    // else only on tick edges.
    always_comb begin
        tickCnt_d  = tick ? '0 : tickCnt_q + 1'b1;
        state_d    = tick ? stateNext : state_q;
        pending_d  = pending_q;
        busy_d     = busy_q;
        regA_d     = regA_q;
        regB_d     = regB_q;
        regOp_d    = regOp_q;
        acc_d      = acc_q;
        iter_d     = iter_q;
        sticky_d   = sticky_q;
        solution_d = solution_q;
        ovf_d      = ovf_q;

        if (state_q == S_IDLE && bus.start && !pending_q) begin
            regA_d    = bus.inpA;
            regB_d    = bus.inpB;
            regOp_d   = bus.op;
            pending_d = 1'b1;
            busy_d    = 1'b1;
        end

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    // A start on the tick edge itself is captured above and
                    // consumed here in the same edge.
                    if (bus.start || pending_q) begin
                        pending_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (regOp_q == OP_MUL) begin
                        acc_d    = '0;
                        iter_d   = regB_q;
                        sticky_d = 1'b0;
                    end
                end
                S_EXEC: begin
                    case (regOp_q)
                        OP_ADD: begin
                            solution_d = addExt[WIDTH-1:0];
                            ovf_d      = addExt[WIDTH];
`ifdef SEQ_ALU_SAT_EN
                            if (addExt[WIDTH]) solution_d = '1;
`endif
                        end
                        OP_SUB: begin
                            solution_d = regA_q - regB_q;
                            ovf_d      = (regA_q < regB_q);
`ifdef SEQ_ALU_SAT_EN
                            if (regA_q < regB_q) solution_d = '0;
`endif
                        end
                        OP_AND: begin
                            solution_d = regA_q & regB_q;
                            ovf_d      = 1'b0;
                        end
                        default: begin
                            solution_d = solution_q;
                            ovf_d      = ovf_q;
                        end
                    endcase
                end
                S_MULT: begin
                    // The sticky flag remembers any carry out of the running
                    // sum, i.e. whether the true product exceeded WIDTH bits.
                    if (iter_q == '0) begin
                        solution_d = acc_q;
                        ovf_d      = sticky_q;
`ifdef SEQ_ALU_SAT_EN
                        if (sticky_q) solution_d = '1;
`endif
                    end else begin
                        acc_d    = accExt[WIDTH-1:0];
                        sticky_d = sticky_q | accExt[WIDTH];
                        iter_d   = iter_q - 1'b1;
                    end
                end
                S_DONE: begin
                    busy_d = 1'b0;
                end
                default: begin
                    busy_d    = 1'b0;
                    pending_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tickCnt_q  <= '0;
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            regA_q     <= '0;
            regB_q     <= '0;
            regOp_q    <= 2'b00;
            acc_q      <= '0;
            iter_q     <= '0;
            sticky_q   <= 1'b0;
            solution_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            tickCnt_q  <= tickCnt_d;
            state_q    <= state_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
            regA_q     <= regA_d;
            regB_q     <= regB_d;
            regOp_q    <= regOp_d;
            acc_q      <= acc_d;
            iter_q     <= iter_d;
            sticky_q   <= sticky_d;
            solution_q <= solution_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.solution   = solution_q;
    assign bus.ovf        = ovf_q;
    assign bus.busy       = busy_q;
    assign bus.done       = (state_q == S_DONE);
    assign bus.prStateLed = state_q;
    assign bus.nxStateLed = stateNext;

endmodule

// File: doc/seq_alu_system.md
Name: seq_alu_system

Overview:
- Parametrised multi-cycle ALU system: controller FSM, operand/accumulator datapath and a tick divider, all in one block.
- Accepts a start request with two operands and an opcode, then steps through LOAD/EXEC (or iterative MULT) at the tick rate.
- Presents the result, an overflow flag and current/next state on LED outputs.
- Next-generation top level for the lab board: generic width, programmable pacing, multiplication by repeated addition.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).
- TICK_DIV, 8, FSM advances once every TICK_DIV clocks (>=1; 1 = every clock).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 add, 01 sub, 10 and, 11 mul.
- inpA  in  WIDTH  operand A.
- inpB  in  WIDTH  operand B.
- solution  out  WIDTH  last result, registered.
- ovf  out  1  overflow/borrow of last result, registered.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  high exactly while state==DONE.
- prStateLed  out  3  present state code.
- nxStateLed  out  3  combinational next state (value loaded at next tick edge).

Behaviour:
- Reset (reset=0, asynchronous) clears everything immediately: state IDLE, tick counter 0, operand/acc/iteration regs 0, pending 0; outputs solution=0, ovf=0, busy=0, done=0, prStateLed=0. A mid-operation reset aborts with no result.
- Tick counter: counts 0..TICK_DIV-1 and wraps; tick = (count==TICK_DIV-1), free-running. TICK_DIV=1 gives tick=1 constantly.
- State codes: IDLE=0, LOAD=1, EXEC=2, MULT=3, DONE=4. Codes 5-7 are illegal and go to IDLE at the next tick.
- State changes only on tick edges.
- IDLE:
  - At any edge with start=1 and pending=0: capture inpA, inpB and op into regA/regB/regOp; set pending=1 and busy=1.
  - At a tick edge with (start or pending): go to LOAD and clear pending. If start and tick coincide, capture and transition happen on the same edge.
  - start outside IDLE, or while pending, is ignored and operands are not recaptured.
- LOAD -> EXEC if regOp!=11. For regOp==11: go to MULT, with acc=0 and iter=regB.
- EXEC -> DONE. Writes solution and ovf:
  - add: A+B mod 2^WIDTH; ovf=carry out.
  - sub: A-B mod 2^WIDTH; ovf=(A<B).
  - and: A&B; ovf=0.
- MULT, each tick:
  - If iter==0: go to DONE; solution=acc; ovf=sticky flag.
  - Else: acc+=regA mod 2^WIDTH; sticky flag |= carry; iter decrements.
  - B=0 takes the DONE branch on the first MULT tick with result 0. Total MULT ticks = B+1.
- DONE -> IDLE; busy clears on that edge. solution and ovf hold until the next result.
- Latency with TICK_DIV=1, counted from the start edge E:
  - add/sub/and: solution valid after E+2, done high during cycle E+2..E+3.
  - mul: solution valid after E+2+B.
- Larger TICK_DIV: each state lasts TICK_DIV clocks, except the IDLE wait, which depends on tick phase.

Optional Feature:
- Macro SEQ_ALU_SAT_EN.
- Defined: saturating results. add/mul overflow gives all-ones; sub borrow gives 0. ovf still set.
- Undefined: wrap modulo 2^WIDTH; ovf set as above.

Test Plan:
- WIDTH=4, TICK_DIV=1; reset low mid-MULT (A=3, B=5, after 2 MULT ticks) -> outputs immediately 0, state IDLE. Release, then start add A=5, B=6 -> solution=11, ovf=0, done one cycle at E+2.
- add A=9, B=9 -> wrap build: solution=2, ovf=1. With SEQ_ALU_SAT_EN: solution=15, ovf=1.
- sub A=3, B=5 -> solution=14 (wrap) or 0 (SAT), ovf=1; and A=12, B=10 -> solution=8, ovf=0.
- mul A=3, B=4 -> solution=12, ovf=0, 5 MULT ticks. mul A=5, B=4 -> solution=4 wrap / 15 SAT, ovf=1. mul A=7, B=0 -> solution=0, ovf=0.
- TICK_DIV=8: start asserted 1 cycle mid-period with A=2, B=3 add -> captured; LOAD entered at next tick; prStateLed steps 0,1,2,4,0 with each non-IDLE state lasting 8 clocks; nxStateLed leads prStateLed. start pulses with A=1 during busy -> ignored; solution=5.
- Operand change after capture: start A=4, B=4 add, then change inpA/inpB to 15 before LOAD -> solution=8.
